// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw buttons in, conditioned pulse/status out.
interface btn_conditioner_if;
    logic [4:0] btn_raw;
    logic [4:0] btn;
    logic       busy;
    logic [4:0] stable;

    modport master (
        output btn_raw,
        input  btn,
        input  busy,
        input  stable
    );

    modport slave (
        input  btn_raw,
        output btn,
        output busy,
        output stable
    );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronises and debounces five raw buttons, then emits one stretched one-hot
// pulse per debounced press, queueing presses that arrive while a pulse is busy.
module btn_conditioner #(
    parameter int DB_CYCLES   = 50000,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input logic              mclk,
    input logic              rst,
    btn_conditioner_if.slave bus
);
    localparam int DBW   = $clog2(DB_CYCLES + 1);
    localparam int PHMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int PW    = $clog2(PHMAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  HOLD_LAST = PW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0]  GAP_LAST  = PW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

    logic [4:0]     sync1_q, sync2_q;
    logic [4:0]     stable_q, stable_d, stable_dly_q;
    logic [DBW-1:0] db_cnt_q [5];
    logic [DBW-1:0] db_cnt_d [5];
    logic [4:0]     rise;
    logic [4:0]     pend_q, pend_d, pend_clr;
    logic [2:0]     pick;
    state_t         state_q, state_d;
    logic [PW-1:0]  ph_q, ph_d;
    logic [2:0]     sel_q, sel_d;
    logic [4:0]     btn_q, btn_d;
    logic           busy_q, busy_d;

    // Two-flop synchroniser, debounce counters, accepted levels and their delayed copy
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '{default: '0};
        end else begin
            sync1_q      <= bus.btn_raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // Per-bit debounce: accept the synchronised level once it has differed long enough
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
        end
    end

    // Press detection and lowest-index pending selection
    always_comb begin
        rise = stable_q & ~stable_dly_q;
        pick = '0;
        for (int unsigned i = 5; i > 0; i--) begin
            if (pend_q[i-1]) pick = 3'(i - 1);
        end
    end

    // FSM state register together with the pending set and registered outputs
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            sel_q   <= '0;
            pend_q  <= '0;
            btn_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            btn_q   <= btn_d;
            busy_q  <= busy_d;
        end
    end

    // FSM next state: take one pending press, hold it, then enforce the gap
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        sel_d    = sel_q;
        pend_clr = '0;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d  = S_HOLD;
                    sel_d    = pick;
                    pend_clr = 5'b00001 << pick;
                    ph_d     = HOLD_LAST;
                end
            end
            S_HOLD: begin
                if (ph_q == '0) begin
                    state_d = S_GAP;
                    ph_d    = GAP_LAST;
                end else begin
                    ph_d = ph_q - PW'(1);
                end
            end
            S_GAP: begin
                if (ph_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q - PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a new press on the bit being serviced survives its own clear
        pend_d = (pend_q & ~pend_clr) | rise;
    end

    // FSM outputs, decoded from the next state so btn/busy can be registered
    always_comb begin
        btn_d  = (state_d == S_HOLD) ? (5'b00001 << sel_d) : '0;
        busy_d = (state_d != S_IDLE);
    end

    assign bus.btn    = btn_q;
    assign bus.busy   = busy_q;
    assign bus.stable = stable_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed vector table, multi-cycle sequences and a
// randomized run, all compared against a time-based reference model.
module tb_btn_conditioner;
    localparam int DB = 4;
    localparam int H  = 3;
    localparam int G  = 2;

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G)
    ) dut (
        .mclk(mclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 mclk = ~mclk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int          ecnt   = 0;
    int          pulse_cnt [5];
    int          base [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
            ecnt++;
        end
    endtask

    task automatic tick_to(input int target);
        while (ecnt < target) tick(1);
    endtask

    function automatic int pdelta(input int b);
        return pulse_cnt[b] - base[b];
    endfunction

    // ---------------- reference model ----------------
    // Pulses are described by their start edge: btn is one-hot for H edges from
    // the start, busy for H+G edges, and a new start needs H+G+1 edges of distance.
    logic [4:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_prev = '0, m_pend = '0;
    int         m_run [5] = '{default: 0};
    bit         m_have = 1'b0;
    int         m_start = 0, m_k = 0, m_edge = 0;
    logic [4:0] m_btn = '0;
    logic       m_busy = 1'b0;

    always @(posedge mclk) begin : model
        logic [4:0] rise_v, pend_v, st_v;
        int         run_v [5];
        int         s_v, k_v, d;
        bit         have_v;
        if (rst) begin
            m_s1 <= '0; m_s2 <= '0; m_st <= '0; m_prev <= '0; m_pend <= '0;
            m_run <= '{default: 0};
            m_have <= 1'b0; m_btn <= '0; m_busy <= 1'b0;
        end else begin
            rise_v = m_st & ~m_prev;
            st_v   = m_st;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_st[i]) begin
                    run_v[i] = m_run[i] + 1;
                    if (run_v[i] == DB) begin
                        st_v[i]  = m_s2[i];
                        run_v[i] = 0;
                    end
                end else begin
                    run_v[i] = 0;
                end
            end
            pend_v = m_pend;
            have_v = m_have;
            s_v    = m_start;
            k_v    = m_k;
            if ((!m_have || (m_edge - m_start) > H + G) && m_pend != '0) begin
                for (int i = 4; i >= 0; i--) if (m_pend[i]) k_v = i;
                pend_v[k_v] = 1'b0;
                have_v = 1'b1;
                s_v    = m_edge;
            end
            pend_v = pend_v | rise_v;
            if (have_v) begin
                d = m_edge - s_v;
                m_btn  <= (d < H) ? 5'(1 << k_v) : 5'b0;
                m_busy <= (d < H + G);
            end else begin
                m_btn  <= '0;
                m_busy <= 1'b0;
            end
            m_have <= have_v; m_start <= s_v; m_k <= k_v; m_pend <= pend_v;
            m_prev <= m_st; m_st <= st_v; m_s2 <= m_s1; m_s1 <= bus.btn_raw;
            m_run  <= run_v;
        end
        m_edge <= m_edge + 1;
    end

    // Compare against the model every cycle and count pulse starts per button
    always @(negedge mclk) begin : monitor
        logic [4:0] prev_btn;
        check("model_btn",    32'(bus.btn),    32'(m_btn));
        check("model_busy",   32'(bus.busy),   32'(m_busy));
        check("model_stable", 32'(bus.stable), 32'(m_st));
        if (bus.btn != '0 && bus.btn != prev_btn) begin
            for (int i = 0; i < 5; i++) if (bus.btn[i]) pulse_cnt[i]++;
        end
        prev_btn = bus.btn;
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int         at;      // edge number (0 = reset release edge)
        logic [4:0] raw;     // btn_raw driven right after that edge
        logic [4:0] btn;
        logic       busy;
        logic [4:0] stable;
    } vec_t;

    vec_t tbl[$];

    initial begin : stim
        int         rises, rise_at, nz;
        bit         early, seen;
        logic       prev;

        // held through reset -> fresh presses; clean press; simultaneous press
        tbl.push_back(vec_t'{  5, 5'h1F, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{  6, 5'h1F, 5'h00, 1'b0, 5'h1F });
        tbl.push_back(vec_t'{  7, 5'h1F, 5'h00, 1'b0, 5'h1F });
        tbl.push_back(vec_t'{  8, 5'h1F, 5'h01, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 10, 5'h1F, 5'h01, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 11, 5'h1F, 5'h00, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 13, 5'h1F, 5'h00, 1'b0, 5'h1F });
        tbl.push_back(vec_t'{ 14, 5'h1F, 5'h02, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 16, 5'h1F, 5'h02, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 17, 5'h1F, 5'h00, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 20, 5'h1F, 5'h04, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 23, 5'h1F, 5'h00, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 26, 5'h1F, 5'h08, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 29, 5'h1F, 5'h00, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 32, 5'h1F, 5'h10, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 34, 5'h1F, 5'h10, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 36, 5'h1F, 5'h00, 1'b1, 5'h1F });
        tbl.push_back(vec_t'{ 37, 5'h1F, 5'h00, 1'b0, 5'h1F });
        tbl.push_back(vec_t'{ 45, 5'h00, 5'h00, 1'b0, 5'h1F });
        tbl.push_back(vec_t'{ 50, 5'h00, 5'h00, 1'b0, 5'h1F });
        tbl.push_back(vec_t'{ 51, 5'h00, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{ 60, 5'h04, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{ 65, 5'h04, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{ 66, 5'h04, 5'h00, 1'b0, 5'h04 });
        tbl.push_back(vec_t'{ 67, 5'h04, 5'h00, 1'b0, 5'h04 });
        tbl.push_back(vec_t'{ 68, 5'h04, 5'h04, 1'b1, 5'h04 });
        tbl.push_back(vec_t'{ 70, 5'h04, 5'h04, 1'b1, 5'h04 });
        tbl.push_back(vec_t'{ 71, 5'h04, 5'h00, 1'b1, 5'h04 });
        tbl.push_back(vec_t'{ 72, 5'h04, 5'h00, 1'b1, 5'h04 });
        tbl.push_back(vec_t'{ 73, 5'h04, 5'h00, 1'b0, 5'h04 });
        tbl.push_back(vec_t'{ 80, 5'h00, 5'h00, 1'b0, 5'h04 });
        tbl.push_back(vec_t'{ 86, 5'h00, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{ 95, 5'h00, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{100, 5'h09, 5'h00, 1'b0, 5'h00 });
        tbl.push_back(vec_t'{106, 5'h09, 5'h00, 1'b0, 5'h09 });
        tbl.push_back(vec_t'{108, 5'h09, 5'h01, 1'b1, 5'h09 });
        tbl.push_back(vec_t'{110, 5'h09, 5'h01, 1'b1, 5'h09 });
        tbl.push_back(vec_t'{111, 5'h09, 5'h00, 1'b1, 5'h09 });
        tbl.push_back(vec_t'{113, 5'h09, 5'h00, 1'b0, 5'h09 });
        tbl.push_back(vec_t'{114, 5'h09, 5'h08, 1'b1, 5'h09 });
        tbl.push_back(vec_t'{116, 5'h09, 5'h08, 1'b1, 5'h09 });
        tbl.push_back(vec_t'{117, 5'h09, 5'h00, 1'b1, 5'h09 });
        tbl.push_back(vec_t'{119, 5'h09, 5'h00, 1'b0, 5'h09 });
        tbl.push_back(vec_t'{125, 5'h00, 5'h00, 1'b0, 5'h09 });
        tbl.push_back(vec_t'{131, 5'h00, 5'h00, 1'b0, 5'h00 });

        // reset for 3 edges with every button held
        bus.btn_raw = 5'h1F;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge mclk);
            #1;
            check("rst_btn",    32'(bus.btn),    32'h0);
            check("rst_busy",   32'(bus.busy),   32'h0);
            check("rst_stable", 32'(bus.stable), 32'h0);
        end
        rst  = 1'b0;
        ecnt = 0;
        base = pulse_cnt;

        foreach (tbl[r]) begin
            tick_to(tbl[r].at);
            check($sformatf("tbl%0d_btn", tbl[r].at),    32'(bus.btn),    32'(tbl[r].btn));
            check($sformatf("tbl%0d_busy", tbl[r].at),   32'(bus.busy),   32'(tbl[r].busy));
            check($sformatf("tbl%0d_stable", tbl[r].at), 32'(bus.stable), 32'(tbl[r].stable));
            bus.btn_raw = tbl[r].raw;
        end
        check("tbl_pulses_b0", 32'(pdelta(0)), 32'd2);
        check("tbl_pulses_b1", 32'(pdelta(1)), 32'd1);
        check("tbl_pulses_b2", 32'(pdelta(2)), 32'd2);
        check("tbl_pulses_b3", 32'(pdelta(3)), 32'd2);
        check("tbl_pulses_b4", 32'(pdelta(4)), 32'd1);

        // bounce: toggle every 2 cycles for 20 cycles, then hold high
        base  = pulse_cnt;
        early = 1'b0;
        for (int j = 0; j < 10; j++) begin
            bus.btn_raw = (j % 2 == 0) ? 5'h02 : 5'h00;
            repeat (2) begin
                tick(1);
                if (bus.stable[1]) early = 1'b1;
            end
        end
        bus.btn_raw = 5'h02;
        rises = 0; rise_at = -1; prev = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (bus.stable[1] && !prev) begin
                rises++;
                rise_at = t;
            end
            prev = bus.stable[1];
        end
        check("bounce_no_early", 32'(early), 32'h0);
        check("bounce_rises",    32'(rises), 32'd1);
        check("bounce_rise_at",  32'(rise_at), 32'd6);
        check("bounce_pulses",   32'(pdelta(1)), 32'd1);
        bus.btn_raw = 5'h00;
        tick(15);

        // 3-cycle glitch is rejected; a DB-long one is accepted
        base = pulse_cnt;
        seen = 1'b0;
        bus.btn_raw = 5'h10;
        tick(3);
        bus.btn_raw = 5'h00;
        repeat (15) begin
            tick(1);
            if (bus.stable[4]) seen = 1'b1;
        end
        check("glitch_stable", 32'(seen), 32'h0);
        check("glitch_pulses", 32'(pdelta(4)), 32'd0);
        seen = 1'b0;
        bus.btn_raw = 5'h08;
        tick(4);
        bus.btn_raw = 5'h00;
        repeat (20) begin
            tick(1);
            if (bus.stable[3]) seen = 1'b1;
        end
        check("edge_glitch_stable", 32'(seen), 32'h1);
        check("edge_glitch_pulses", 32'(pdelta(3)), 32'd1);

        // press/release/press of button 1 around button 0's pulse
        base = pulse_cnt;
        begin
            int t0;
            t0 = ecnt;
            bus.btn_raw = 5'h01;
            tick_to(t0 + 3);  bus.btn_raw = 5'h03;
            tick_to(t0 + 9);
            check("merge_hold0",   32'(bus.btn), 32'h01);
            check("merge_stable1", 32'(bus.stable[1]), 32'h1);
            tick_to(t0 + 10); bus.btn_raw = 5'h01;
            tick_to(t0 + 14);
            check("merge_first1",  32'(bus.btn), 32'h02);
            tick_to(t0 + 17); bus.btn_raw = 5'h03;
            tick_to(t0 + 25);
            check("merge_second1", 32'(bus.btn), 32'h02);
            tick_to(t0 + 40); bus.btn_raw = 5'h00;
            tick_to(t0 + 60);
        end
        check("merge_pulses_b0", 32'(pdelta(0)), 32'd1);
        check("merge_pulses_b1", 32'(pdelta(1)), 32'd2);

        // reset during HOLD with button 2 pending
        base = pulse_cnt;
        begin
            int t0;
            t0 = ecnt;
            bus.btn_raw = 5'h05;
            tick_to(t0 + 9);
            check("rstmid_hold", 32'(bus.btn), 32'h01);
            rst = 1'b1;
            tick(1);
            check("rstmid_btn",    32'(bus.btn),    32'h0);
            check("rstmid_busy",   32'(bus.busy),   32'h0);
            check("rstmid_stable", 32'(bus.stable), 32'h0);
            rst = 1'b0;
            bus.btn_raw = 5'h00;
            nz = 0;
            repeat (30) begin
                tick(1);
                if (bus.btn != '0) nz++;
            end
        end
        check("rstmid_no_pulse", 32'(nz), 32'd0);
        check("rstmid_pend_b2",  32'(pdelta(2)), 32'd0);

        // randomized run checked by the model each cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)
                bus.btn_raw[$urandom_range(0, 4)] = ~bus.btn_raw[$urandom_range(0, 4)];
            if ($urandom_range(0, 29) == 0)
                bus.btn_raw = 5'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        bus.btn_raw = 5'h00;
        tick(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
